// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with burst hold, locked transfers and SPLIT masking.
// Drives the one-hot grant plus the address- and data-phase master selects.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    input  logic [NUM_MASTERS-1:0] HSPLIT,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic [MW-1:0]          HMASTER_DATA,
    output logic                   HMASTLOCK
);

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        BURST  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_BUSY   = 2'd1;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;
    localparam logic [1:0] R_SPLIT  = 2'd3;

    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_ONEHOT =
        {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

    state_t                   state;
    logic [NUM_MASTERS-1:0]   split_mask;
    logic [MW-1:0]            rr_last;
    logic [3:0]               beats_left;
    logic                     split_force;

    logic [MW-1:0]            gidx;
    logic [MW-1:0]            winner;
    logic                     win_real;
    logic [NUM_MASTERS-1:0]   eligible;
    logic [NUM_MASTERS-1:0]   grant_next;
    logic [NUM_MASTERS-1:0]   split_set;
    logic                     split_evt;
    logic                     arb_ok;
    logic                     lock_next;
    logic [3:0]               beats_next;
    state_t                   state_next;

    // Grant decode, round-robin winner selection and next-state decisions
    always_comb begin
        int j;
        gidx       = '0;
        winner     = DEF_IDX;
        win_real   = 1'b0;
        grant_next = '0;
        split_set  = '0;
        beats_next = beats_left;
        state_next = ARB;
        j          = 0;

        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (HGRANT[i]) gidx = MW'(i);
        end

        eligible = HBUSREQ & ~split_mask;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            j = (int'(rr_last) + k) % NUM_MASTERS;
            if (!win_real && eligible[j]) begin
                winner   = MW'(j);
                win_real = 1'b1;
            end
        end
        grant_next[winner] = 1'b1;

        split_evt = (HRESP == R_SPLIT) && !HREADY;
        if (split_evt && (HMASTER_DATA != DEF_IDX)) begin
            split_set[HMASTER_DATA] = 1'b1;
        end

        arb_ok = HREADY && (split_force ||
                 (state == ARB) ||
                 (state == BURST && beats_left == 4'd1 && HTRANS == T_SEQ) ||
                 (state == LOCKED && !HLOCK[gidx]));

        case (HTRANS)
            T_NONSEQ: begin
                case (HBURST)
                    3'd2, 3'd3: beats_next = 4'd3;
                    3'd4, 3'd5: beats_next = 4'd7;
                    3'd6, 3'd7: beats_next = 4'd15;
                    default:    beats_next = 4'd0;
                endcase
            end
            T_SEQ:   beats_next = (beats_left == 4'd0) ? 4'd0 : beats_left - 4'd1;
            T_BUSY:  beats_next = beats_left;
            T_IDLE:  beats_next = 4'd0;
            default: beats_next = beats_left;
        endcase

        lock_next = HLOCK[gidx];
        if (lock_next) begin
            state_next = LOCKED;
        end else if (beats_next != 4'd0) begin
            state_next = BURST;
        end else begin
            state_next = ARB;
        end
    end

    // Grant, master pipeline, burst/lock FSM and split mask registers
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            HGRANT       <= DEF_ONEHOT;
            HMASTER      <= DEF_IDX;
            HMASTER_DATA <= DEF_IDX;
            HMASTLOCK    <= 1'b0;
            split_mask   <= '0;
            rr_last      <= DEF_IDX;
            beats_left   <= 4'd0;
            split_force  <= 1'b0;
            state        <= ARB;
        end else begin
            split_mask <= (split_mask & ~HSPLIT) | split_set;
            if (split_evt) begin
                beats_left  <= 4'd0;
                state       <= ARB;
                split_force <= 1'b1;
            end else if (HREADY) begin
                split_force <= 1'b0;
                if (arb_ok) begin
                    HGRANT <= grant_next;
                    if (win_real) rr_last <= winner;
                end
                HMASTER      <= gidx;
                HMASTER_DATA <= HMASTER;
                HMASTLOCK    <= lock_next;
                beats_left   <= beats_next;
                state        <= state_next;
            end
        end
    end

endmodule
